// File: rtl/morse_pkg.sv
// Shared types, timing multipliers and the Morse-to-ASCII table for the
// Morse key decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        WORD_WAIT
    } state_t;

    localparam int DAH_THRESH_U = 2;
    localparam int LETTER_GAP_U = 2;
    localparam int WORD_GAP_U   = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h3F;

    // Symbol bits hold the first element at the highest used position
    // (elements shift in at the LSB); 0 = dit, 1 = dah.
    function automatic logic [7:0] morseLookup(input logic [2:0] len,
                                               input logic [5:0] bits,
                                               input logic       ovf);
        logic [7:0] c;
        c = ASCII_ERR;
        if (!ovf) begin
            case (len)
                3'd1: begin
                    case (bits[0])
                        1'b0:    c = 8'h45; // E
                        default: c = 8'h54; // T
                    endcase
                end
                3'd2: begin
                    case (bits[1:0])
                        2'b00:   c = 8'h49; // I
                        2'b01:   c = 8'h41; // A
                        2'b10:   c = 8'h4E; // N
                        default: c = 8'h4D; // M
                    endcase
                end
                3'd3: begin
                    case (bits[2:0])
                        3'b000:  c = 8'h53; // S
                        3'b001:  c = 8'h55; // U
                        3'b010:  c = 8'h52; // R
                        3'b011:  c = 8'h57; // W
                        3'b100:  c = 8'h44; // D
                        3'b101:  c = 8'h4B; // K
                        3'b110:  c = 8'h47; // G
                        default: c = 8'h4F; // O
                    endcase
                end
                3'd4: begin
                    case (bits[3:0])
                        4'b0000: c = 8'h48; // H
                        4'b0001: c = 8'h56; // V
                        4'b0010: c = 8'h46; // F
                        4'b0100: c = 8'h4C; // L
                        4'b0110: c = 8'h50; // P
                        4'b0111: c = 8'h4A; // J
                        4'b1000: c = 8'h42; // B
                        4'b1001: c = 8'h58; // X
                        4'b1010: c = 8'h43; // C
                        4'b1011: c = 8'h59; // Y
                        4'b1100: c = 8'h5A; // Z
                        4'b1101: c = 8'h51; // Q
                        default: c = ASCII_ERR;
                    endcase
                end
                3'd5: begin
                    case (bits[4:0])
                        5'b11111: c = 8'h30;
                        5'b01111: c = 8'h31;
                        5'b00111: c = 8'h32;
                        5'b00011: c = 8'h33;
                        5'b00001: c = 8'h34;
                        5'b00000: c = 8'h35;
                        5'b10000: c = 8'h36;
                        5'b11000: c = 8'h37;
                        5'b11100: c = 8'h38;
                        5'b11110: c = 8'h39;
                        default:  c = ASCII_ERR;
                    endcase
                end
                default: c = ASCII_ERR;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a stable-sample counter. The level,
// rise and fall outputs all update on the same clock edge.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Bring the raw key into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], key_i};
    end

    // Count consecutive samples that differ from the accepted level; flip on the last one.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            rise_d  = sync_q[1];
            fall_d  = ~sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Straight-key Morse receiver: debounces the key, times marks and gaps in
// dit units, and emits ASCII characters and word spaces with a strobe.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 1200000,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int MAX_ELEMENTS    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic [7:0] char_data,
    output logic       char_strb,
    output logic       dit_out,
    output logic       dah_out,
    output logic       key_active,
    output logic       busy
);

    localparam int TIMER_MAX = 8 * UNIT_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    // The timer reads k in the k-th cycle after a debounced edge, so the
    // "reaches N units" cycle is the one where it reads N*UNIT-1 and the
    // registered strobe lands exactly N*UNIT cycles after the edge.
    localparam logic [TW-1:0] T_SAT      = TW'(TIMER_MAX);
    localparam logic [TW-1:0] T_DAH      = TW'(DAH_THRESH_U * UNIT_CYCLES);
    localparam logic [TW-1:0] T_LETTER_L = TW'(LETTER_GAP_U * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T_WORD_L   = TW'(WORD_GAP_U * UNIT_CYCLES - 1);
    localparam logic [2:0]    LEN_MAX    = 3'(MAX_ELEMENTS);

    logic keyLevel, keyRise, keyFall;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [2:0]              symLen_q, symLen_d;
    logic [MAX_ELEMENTS-1:0] symBits_q, symBits_d;
    logic                    symOvf_q, symOvf_d;
    logic [7:0]              charData_q, charData_d;
    logic                    charStrb_q, charStrb_d;
    logic                    dit_q, dit_d;
    logic                    dah_q, dah_d;
    logic [5:0]              lookupBits;
    logic                    isDah;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_i  (key_in),
        .level_o(keyLevel),
        .rise_o (keyRise),
        .fall_o (keyFall)
    );

    // Single mark/space timer: restarts on every debounced edge, saturates at 8 units.
    always_comb begin
        timer_d = timer_q;
        if (keyRise || keyFall)  timer_d = TW'(1);
        else if (timer_q != T_SAT) timer_d = timer_q + 1'b1;
    end

    // Fit the symbol register onto the fixed-width lookup input.
    always_comb begin
        lookupBits = '0;
        for (int i = 0; i < MAX_ELEMENTS && i < 6; i++) lookupBits[i] = symBits_q[i];
    end

    assign isDah = (timer_q >= T_DAH);

    // Next-state, symbol accumulation and output pulse generation.
    always_comb begin
        state_d    = state_q;
        symLen_d   = symLen_q;
        symBits_d  = symBits_q;
        symOvf_d   = symOvf_q;
        charData_d = charData_q;
        charStrb_d = 1'b0;
        dit_d      = 1'b0;
        dah_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (keyRise) state_d = MARK;
            end
            MARK: begin
                if (keyFall) begin
                    dit_d = ~isDah;
                    dah_d = isDah;
                    if (symLen_q == LEN_MAX) begin
                        symOvf_d = 1'b1;
                    end else begin
                        symBits_d = {symBits_q[MAX_ELEMENTS-2:0], isDah};
                        symLen_d  = symLen_q + 3'd1;
                    end
                    state_d = SPACE;
                end
            end
            SPACE: begin
                if (timer_q == T_LETTER_L) begin
                    charData_d = morseLookup(symLen_q, lookupBits, symOvf_q);
                    charStrb_d = 1'b1;
                    symLen_d   = '0;
                    symBits_d  = '0;
                    symOvf_d   = 1'b0;
                    state_d    = keyRise ? MARK : WORD_WAIT;
                end else if (keyRise) begin
                    state_d = MARK;
                end
            end
            WORD_WAIT: begin
                if (timer_q == T_WORD_L) begin
                    charData_d = ASCII_SPACE;
                    charStrb_d = 1'b1;
                    state_d    = keyRise ? MARK : IDLE;
                end else if (keyRise) begin
                    state_d = MARK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer, symbol and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            symLen_q   <= '0;
            symBits_q  <= '0;
            symOvf_q   <= 1'b0;
            charData_q <= 8'h00;
            charStrb_q <= 1'b0;
            dit_q      <= 1'b0;
            dah_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            symLen_q   <= symLen_d;
            symBits_q  <= symBits_d;
            symOvf_q   <= symOvf_d;
            charData_q <= charData_d;
            charStrb_q <= charStrb_d;
            dit_q      <= dit_d;
            dah_q      <= dah_d;
        end
    end

    assign char_data  = charData_q;
    assign char_strb  = charStrb_q;
    assign dit_out    = dit_q;
    assign dah_out    = dah_q;
    assign key_active = keyLevel;
    assign busy       = (state_q == MARK) || (state_q == SPACE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for the Morse key decoder with UNIT_CYCLES=20 and
// DEBOUNCE_CYCLES=4, so a letter gap is 40 cycles and a word gap 100.
module tb_morse_key_decoder;

    logic       clk;
    logic       rst_n;
    logic       key_in;
    logic [7:0] char_data;
    logic       char_strb;
    logic       dit_out;
    logic       dah_out;
    logic       key_active;
    logic       busy;

    int nVec  = 0;
    int nFail = 0;

    // Event log filled by the monitor
    int         cyc        = 0;
    int         lastFall   = 0;
    int         charCount  = 0;
    int         ditCount   = 0;
    int         dahCount   = 0;
    int         riseCount  = 0;
    logic       prevActive = 1'b0;
    logic [7:0] charLog [0:63];
    int         charCyc [0:63];
    int         fallAt  [0:63];

    morse_key_decoder #(
        .UNIT_CYCLES    (20),
        .DEBOUNCE_CYCLES(4),
        .MAX_ELEMENTS   (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .char_data (char_data),
        .char_strb (char_strb),
        .dit_out   (dit_out),
        .dah_out   (dah_out),
        .key_active(key_active),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record debounced edges, element pulses and strobes on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prevActive && !key_active) lastFall = cyc;
        if (!prevActive && key_active) riseCount = riseCount + 1;
        prevActive = key_active;
        if (dit_out) ditCount = ditCount + 1;
        if (dah_out) dahCount = dahCount + 1;
        if (char_strb && charCount < 64) begin
            charLog[charCount] = char_data;
            charCyc[charCount] = cyc;
            fallAt[charCount]  = lastFall;
            charCount = charCount + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic keyPress(input int n);
        key_in = 1'b1;
        tick(n);
        key_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 1'b0;
        tick(3);
        nVec++;
        if ({char_data, char_strb, dit_out, dah_out, key_active, busy} !== 13'd0) begin
            nFail++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {char_data, char_strb, dit_out, dah_out, key_active, busy});
        end
        rst_n = 1'b1;
        tick(10);
        nVec++;
        if ({char_data, char_strb, dit_out, dah_out, key_active, busy} !== 13'd0) begin
            nFail++;
            $display("[TB] FAIL post_reset_idle: got %h, expected 0",
                     {char_data, char_strb, dit_out, dah_out, key_active, busy});
        end
    endtask

    task automatic test_letter_a(input string tag);
        int b, d0, h0;
        b  = charCount;
        d0 = ditCount;
        h0 = dahCount;
        keyPress(20);
        tick(20);
        keyPress(60);
        tick(200);
        nVec++;
        if (ditCount - d0 !== 1 || dahCount - h0 !== 1) begin
            nFail++;
            $display("[TB] FAIL %s_elements: dits %0d dahs %0d, expected 1 and 1",
                     tag, ditCount - d0, dahCount - h0);
        end
        nVec++;
        if (charCount - b !== 2) begin
            nFail++;
            $display("[TB] FAIL %s_count: got %0d strobes, expected 2", tag, charCount - b);
        end else begin
            nVec++;
            if (charLog[b] !== 8'h41) begin
                nFail++;
                $display("[TB] FAIL %s_char: got %h, expected 41", tag, charLog[b]);
            end
            nVec++;
            if (charCyc[b] - fallAt[b] !== 40) begin
                nFail++;
                $display("[TB] FAIL %s_latency: got %0d, expected 40", tag, charCyc[b] - fallAt[b]);
            end
            nVec++;
            if (charLog[b+1] !== 8'h20 || charCyc[b+1] - charCyc[b] !== 60) begin
                nFail++;
                $display("[TB] FAIL %s_space: got %h after %0d, expected 20 after 60",
                         tag, charLog[b+1], charCyc[b+1] - charCyc[b]);
            end
        end
        nVec++;
        if (char_data !== 8'h20 || busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL %s_hold: char_data %h busy %b, expected 20 and 0", tag, char_data, busy);
        end
    endtask

    task automatic test_digit_zero();
        int b;
        logic busyMid;
        b = charCount;
        for (int i = 0; i < 5; i++) begin
            keyPress(60);
            if (i < 4) begin
                tick(10);
                if (i == 2) busyMid = busy;
                tick(10);
            end
        end
        tick(30);
        nVec++;
        if (busyMid !== 1'b1 || busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL zero_busy_pending: got %b/%b, expected 1/1", busyMid, busy);
        end
        tick(25);
        nVec++;
        if (busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL zero_busy_after: got %b, expected 0", busy);
        end
        tick(150);
        nVec++;
        if (charCount - b !== 2 || charLog[b] !== 8'h30 || charLog[b+1] !== 8'h20) begin
            nFail++;
            $display("[TB] FAIL zero_char: got %0d strobes first %h, expected 2 strobes 30 then 20",
                     charCount - b, charLog[b]);
        end
    endtask

    task automatic test_overflow();
        int b;
        b = charCount;
        for (int i = 0; i < 7; i++) begin
            keyPress(20);
            tick(20);
        end
        tick(180);
        nVec++;
        if (charCount - b !== 2 || charLog[b] !== 8'h3F) begin
            nFail++;
            $display("[TB] FAIL overflow_char: got %0d strobes first %h, expected 2 strobes 3f",
                     charCount - b, charLog[b]);
        end
        b = charCount;
        for (int i = 0; i < 4; i++) begin
            keyPress(20);
            tick(20);
        end
        tick(180);
        nVec++;
        if (charCount - b !== 2 || charLog[b] !== 8'h48) begin
            nFail++;
            $display("[TB] FAIL after_overflow_h: got %0d strobes first %h, expected 2 strobes 48",
                     charCount - b, charLog[b]);
        end
    endtask

    task automatic test_back_to_back();
        int b;
        b = charCount;
        keyPress(20);
        tick(50);
        keyPress(60);
        tick(200);
        nVec++;
        if (charCount - b !== 3) begin
            nFail++;
            $display("[TB] FAIL et_count: got %0d strobes, expected 3", charCount - b);
        end else begin
            nVec++;
            if (charLog[b] !== 8'h45 || charCyc[b] - fallAt[b] !== 40) begin
                nFail++;
                $display("[TB] FAIL et_e: got %h at %0d, expected 45 at 40",
                         charLog[b], charCyc[b] - fallAt[b]);
            end
            nVec++;
            if (charLog[b+1] !== 8'h54 || charLog[b+2] !== 8'h20) begin
                nFail++;
                $display("[TB] FAIL et_t: got %h %h, expected 54 20", charLog[b+1], charLog[b+2]);
            end
        end
    endtask

    task automatic test_glitch();
        int b, d0, h0, r0;
        b  = charCount;
        d0 = ditCount;
        h0 = dahCount;
        r0 = riseCount;
        for (int i = 0; i < 5; i++) begin
            keyPress(2);
            tick(10);
        end
        tick(20);
        nVec++;
        if (riseCount !== r0 || ditCount !== d0 || dahCount !== h0 || charCount !== b) begin
            nFail++;
            $display("[TB] FAIL glitch: rises %0d dits %0d dahs %0d chars %0d, expected none",
                     riseCount - r0, ditCount - d0, dahCount - h0, charCount - b);
        end
    endtask

    task automatic test_reset_mid_dah();
        int b, d0, h0;
        key_in = 1'b1;
        tick(50);
        nVec++;
        if (busy !== 1'b1 || key_active !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL mid_dah_active: busy %b key_active %b, expected 1 1", busy, key_active);
        end
        rst_n = 1'b0;
        tick(1);
        nVec++;
        if ({char_data, char_strb, dit_out, dah_out, key_active, busy} !== 13'd0) begin
            nFail++;
            $display("[TB] FAIL mid_dah_reset: got %h, expected 0",
                     {char_data, char_strb, dit_out, dah_out, key_active, busy});
        end
        key_in = 1'b0;
        tick(3);
        b  = charCount;
        d0 = ditCount;
        h0 = dahCount;
        rst_n = 1'b1;
        tick(200);
        nVec++;
        if (charCount !== b || ditCount !== d0 || dahCount !== h0 || char_data !== 8'h00 || busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL after_reset_quiet: chars %0d elems %0d data %h busy %b, expected 0 0 00 0",
                     charCount - b, ditCount - d0 + dahCount - h0, char_data, busy);
        end
        test_letter_a("reset_a");
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 1'b0;
        test_reset();
        test_letter_a("a");
        test_digit_zero();
        test_overflow();
        test_back_to_back();
        test_glitch();
        test_reset_mid_dah();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
